// File: rtl/sensor_conditioner_if.sv
// Detector, 1 s tick and service handshake between the road sensor front end and the highway controller.
interface sensor_conditioner_if;
  logic       sensor_raw;
  logic       pulse;
  logic       enable_countryroad;
  logic       sensor;
  logic       sensor_db;
  logic [5:0] wait_sec;

  modport master (
    output sensor_raw, pulse, enable_countryroad,
    input  sensor, sensor_db, wait_sec
  );

  modport slave (
    input  sensor_raw, pulse, enable_countryroad,
    output sensor, sensor_db, wait_sec
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Country-road vehicle sensor conditioning: synchronise, debounce, qualify presence,
// latch a request until the country road has been served, and time the wait.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned MIN_PRESENCE_SEC = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  sensor_conditioner_if.slave bus
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned QUAL_W = (MIN_PRESENCE_SEC > 1) ? $clog2(MIN_PRESENCE_SEC) : 1;
  localparam int unsigned WAIT_W = 6;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    REQUEST = 2'd2,
    SERVICE = 2'd3
  } state_e;

  logic              s1, s2;
  logic [DB_W-1:0]   db_cnt;
  logic              sensor_db_q;
  logic              ecr_q;
  logic              svc_done;

  state_e            state, state_nxt;
  logic [QUAL_W-1:0] qual_cnt, qual_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic              sensor_q, sensor_nxt;

  // Two-flop synchroniser feeding a consecutive-sample debouncer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      db_cnt      <= '0;
      sensor_db_q <= 1'b0;
    end else begin
      s1 <= bus.sensor_raw;
      s2 <= s1;
      if (s2 == sensor_db_q) begin
        db_cnt <= '0;
      end else if (32'(db_cnt) == DEBOUNCE_CYCLES - 32'd1) begin
        sensor_db_q <= s2;
        db_cnt      <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ecr_q <= 1'b0;
    else        ecr_q <= bus.enable_countryroad;
  end

  assign svc_done = ecr_q & ~bus.enable_countryroad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      qual_cnt <= '0;
      wait_q   <= '0;
      sensor_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      qual_cnt <= qual_nxt;
      wait_q   <= wait_nxt;
      sensor_q <= sensor_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    qual_nxt   = qual_cnt;
    wait_nxt   = wait_q;
    sensor_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sensor_db_q) begin
          qual_nxt  = '0;
          state_nxt = (MIN_PRESENCE_SEC == 0) ? REQUEST : QUALIFY;
        end
      end
      QUALIFY: begin
        // Loss of presence wins over a coincident tick
        if (!sensor_db_q) begin
          state_nxt = IDLE;
        end else if (bus.pulse) begin
          if (32'(qual_cnt) + 32'd1 >= MIN_PRESENCE_SEC) state_nxt = REQUEST;
          else                                           qual_nxt  = qual_cnt + QUAL_W'(1);
        end
      end
      REQUEST: begin
        if (bus.enable_countryroad) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (svc_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Wait timer runs only while the request is pending, frozen during service
    if (state_nxt == IDLE || state_nxt == QUALIFY) begin
      wait_nxt = '0;
    end else if (state == IDLE || state == QUALIFY) begin
      wait_nxt = '0;
    end else if (state == REQUEST && bus.pulse && wait_q != WAIT_MAX) begin
      wait_nxt = wait_q + WAIT_W'(1);
    end

    sensor_nxt = (state_nxt == REQUEST) || (state_nxt == SERVICE);
  end

  assign bus.sensor    = sensor_q;
  assign bus.sensor_db = sensor_db_q;
  assign bus.wait_sec  = wait_q;

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Upstream conditioning stage for the country-road vehicle sensor. It synchronises and debounces the raw detector input and requires the vehicle to be present for a minimum number of seconds. It then latches a service request onto the `sensor` input of the highway controller. The request is held until the country road has been served, which is signalled by a falling edge of `enable_countryroad`. It also reports how long the request has been waiting.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive clk samples of a new level before the debounced level changes. Must be >=1.
- MIN_PRESENCE_SEC, 2: number of 1 s pulses of continuous debounced presence before a request is raised. 0 means raise the request immediately.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- sensor_raw  in  1  asynchronous raw vehicle detector, 1 = vehicle present
- pulse  in  1  one-clk-wide 1 s tick from pulse_1s
- enable_countryroad  in  1  high while the country-road FSM is serving
- sensor  out  1  latched vehicle request to the highway FSM
- sensor_db  out  1  debounced presence level, for debug/visibility
- wait_sec  out  6  seconds spent in REQUEST, saturating

Behaviour:
- Reset: the reset is synchronous, active-low, on the rising edge of clk. While rst_n=0 the following are all cleared:
  - sync flops, debounce counter and qualify counter
  - enable_countryroad delay flop
  - outputs: sensor=0, sensor_db=0, wait_sec=0
  - state=IDLE
  - Reset mid-operation drops any pending request the same edge.
- Synchroniser: two flops, s1 then s2, sampling sensor_raw. Only s2 is used downstream.
- Debounce:
  - If s2 == sensor_db, the counter clears to 0.
  - Otherwise the counter increments. On the edge where the counter would reach DEBOUNCE_CYCLES, sensor_db <= s2 and the counter clears.
  - Latency from a stable raw change to the sensor_db change is 2 + DEBOUNCE_CYCLES clks.
  - A glitch shorter than DEBOUNCE_CYCLES samples never reaches sensor_db.
- enable_countryroad is registered once (ecr_q). The service-done condition is ecr_q=1 and enable_countryroad=0.
- FSM, registered, one transition per clk:
  - IDLE: if sensor_db=1, go to QUALIFY with qual_cnt=0. If MIN_PRESENCE_SEC=0, go directly to REQUEST instead.
  - QUALIFY:
    - If sensor_db=0, go to IDLE. This takes priority over a simultaneous pulse.
    - Otherwise, on pulse, qual_cnt++. The pulse that makes qual_cnt equal MIN_PRESENCE_SEC moves the FSM to REQUEST.
  - REQUEST: request is latched; sensor_db falling does NOT withdraw it. If enable_countryroad=1, go to SERVICE.
  - SERVICE: on service-done, go to IDLE. If the vehicle is still present, it must requalify from IDLE.
- sensor: registered and decoded from the next state. It is 1 in the same cycle the state register holds REQUEST or SERVICE, and 0 otherwise.
- wait_sec:
  - Cleared on entry to REQUEST and while in IDLE/QUALIFY.
  - In REQUEST, +1 per pulse, saturating at 63 with no wrap.
  - Held during SERVICE; cleared on return to IDLE.
- enable_countryroad already high on entry to REQUEST: go to SERVICE on the next clk.
- enable_countryroad falling while in REQUEST or QUALIFY: ignored.
- pulse while in IDLE or SERVICE: no effect.

Test Plan (DEBOUNCE_CYCLES=4, MIN_PRESENCE_SEC=2):
1. Reset then idle: rst_n=0 for 3 clk with sensor_raw=1 -> sensor=0, sensor_db=0, wait_sec=0 throughout. After release, sensor_db rises exactly 6 clk after the first sampling edge.
2. Glitch rejection: sensor_raw high for 3 clk, then low -> sensor_db stays 0 and sensor stays 0.
3. Qualification:
   - Raw held high; after sensor_db=1, apply 2 pulses -> sensor=1 on the clk after the 2nd pulse.
   - Repeat, but drop raw so that sensor_db falls in the same cycle as the 2nd pulse -> FSM returns to IDLE and sensor=0.
4. Latch and wait count: request raised, raw dropped, 5 pulses applied -> sensor stays 1 and wait_sec=5.
   - Run 70 pulses -> wait_sec saturates at 63.
5. Service handshake:
   - enable_countryroad 0->1 -> state SERVICE, sensor=1, wait_sec held.
   - enable_countryroad 1->0 -> sensor=0 and wait_sec=0 within 2 clk.
   - Raw still high -> a new request is raised after 2 more pulses.
6. Reset mid-REQUEST: with sensor=1 and wait_sec=7, assert rst_n=0 for 1 clk -> sensor=0, wait_sec=0, state IDLE on that edge.
